melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer_if.sv | 23 ++
 rtl/melody_sequencer.sv | 138 +++++++++++++
 tb/tb_melody_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a player controller and melody_sequencer.
// Valid/ready: none; start/stop are level commands sampled every rising edge, status outputs are cycle-accurate.
interface melody_sequencer_if;
    logic       start;
    logic       stop;
    logic       song_sel;
    logic       loop;
    logic [7:0] fullnote;
    logic       busy;
    logic       note_strobe;
    logic       done;
    logic [1:0] state_dbg;

    modport master (
        output start, stop, song_sel, loop,
        input  fullnote, busy, note_strobe, done, state_dbg
    );

    modport slave (
        input  start, stop, song_sel, loop,
        output fullnote, busy, note_strobe, done, state_dbg
    );
endinterface

// File: rtl/melody_sequencer.sv
// Two-song melody player: walks a small note ROM, holding each note for dur beat ticks,
// with an optional silent gap at the end of each note so repeated notes are audible.
module melody_sequencer #(
    parameter int TICK_DIV   = 1562500,
    parameter int GAP_CYCLES = TICK_DIV / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    melody_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_FINISH} state_t;

    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
    localparam logic [23:0] GAP_START = 24'(TICK_DIV - GAP_CYCLES);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  beat_q, beat_d;
    logic [23:0] presc_q, presc_d;
    logic [5:0]  note_q, note_d;
    logic        song_q, song_d;
    logic        strobe_q, strobe_d;
    logic        done_q, done_d;

    logic [9:0]  rom_word;
    logic [3:0]  rom_dur;
    logic [5:0]  rom_note;
    logic        in_gap;

    always_comb begin
        rom_word = 10'd0;
        case ({song_q, idx_q})
            6'd0:  rom_word = {4'd2, 6'd27};
            6'd1:  rom_word = {4'd2, 6'd31};
            6'd2:  rom_word = {4'd2, 6'd34};
            6'd3:  rom_word = {4'd4, 6'd39};
            6'd32: rom_word = {4'd1, 6'd39};
            6'd33: rom_word = {4'd1, 6'd0};
            6'd34: rom_word = {4'd1, 6'd39};
            6'd35: rom_word = {4'd1, 6'd0};
            6'd36: rom_word = {4'd4, 6'd27};
            default: rom_word = 10'd0;
        endcase
    end

    assign rom_dur  = rom_word[9:6];
    assign rom_note = rom_word[5:0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        beat_d   = beat_q;
        presc_d  = presc_q;
        note_d   = note_q;
        song_d   = song_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        if (bus.stop) begin
            state_d = S_IDLE;
        end else if (bus.start) begin
            // Accepted start always restarts from entry 0, even mid-song.
            state_d = S_LOAD;
            song_d  = bus.song_sel;
            idx_d   = 5'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (rom_dur == 4'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        note_d   = rom_note;
                        beat_d   = rom_dur;
                        presc_d  = 24'd0;
                        strobe_d = 1'b1;
                        state_d  = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (presc_q == TICK_LAST) begin
                        presc_d = 24'd0;
                        beat_d  = beat_q - 4'd1;
                        if (beat_q == 4'd1) begin
                            // Running off the end of a song's ROM page counts as an end marker.
                            if (idx_q == 5'd31) begin
                                state_d = S_FINISH;
                            end else begin
                                idx_d   = idx_q + 5'd1;
                                state_d = S_LOAD;
                            end
                        end
                    end else begin
                        presc_d = presc_q + 24'd1;
                    end
                end
                S_FINISH: begin
                    if (bus.loop && (idx_q != 5'd0)) begin
                        idx_d   = 5'd0;
                        state_d = S_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 5'd0;
            beat_q   <= 4'd0;
            presc_q  <= 24'd0;
            note_q   <= 6'd0;
            song_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            presc_q  <= presc_d;
            note_q   <= note_d;
            song_q   <= song_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign in_gap = (GAP_CYCLES != 0) && (beat_q == 4'd1) && (presc_q >= GAP_START);

    assign bus.fullnote    = ((state_q == S_PLAY) && !in_gap) ? {2'b00, note_q} : 8'd0;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.note_strobe = strobe_q;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer at TICK_DIV=4 (one instance with a 1-cycle gap, one without).
module tb_melody_sequencer;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    melody_sequencer_if bus ();
    melody_sequencer_if bus0 ();

    melody_sequencer #(.TICK_DIV(TD), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    melody_sequencer #(.TICK_DIV(TD), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       song_sel;
        logic       loop;
        logic [7:0] fn;
        logic       busy;
        logic       strobe;
        logic       done;
    } vec_t;

    vec_t        vecs[17];
    logic [10:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] obs(input bit sel);
        if (sel) return {bus0.fullnote, bus0.busy, bus0.note_strobe, bus0.done};
        return {bus.fullnote, bus.busy, bus.note_strobe, bus.done};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic sp, input logic ss, input logic lp);
        bus.start = st; bus.stop = sp; bus.song_sel = ss; bus.loop = lp;
    endtask

    task automatic push_load();
        exp_q.push_back({8'd0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic push_finish();
        exp_q.push_back({8'd0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic push_entry(input int note, input int dur, input int gap);
        push_load();
        for (int j = 0; j < dur * TD; j++)
            exp_q.push_back({((j >= dur * TD - gap) ? 8'd0 : 8'(note)), 1'b1, (j == 0), 1'b0});
    endtask

    task automatic push_song(input int song, input int gap);
        if (song == 0) begin
            push_entry(27, 2, gap); push_entry(31, 2, gap);
            push_entry(34, 2, gap); push_entry(39, 4, gap);
        end else begin
            push_entry(39, 1, gap); push_entry(0, 1, gap); push_entry(39, 1, gap);
            push_entry(0, 1, gap);  push_entry(27, 4, gap);
        end
        push_load();
        push_finish();
    endtask

    // Start input must already be set; it is dropped after the first edge.
    task automatic run_trace(input string name, input bit sel, output int strobes, output int done_at);
        logic [10:0] e;
        logic [10:0] o;
        int k;
        strobes = 0;
        done_at = -1;
        k = 0;
        while (exp_q.size() > 0) begin
            cyc();
            bus.start  = 1'b0;
            bus0.start = 1'b0;
            e = exp_q.pop_front();
            o = obs(sel);
            check($sformatf("%s_c%0d", name, k), 32'(o), 32'(e));
            if (o[1]) strobes++;
            if (o[0] && done_at < 0) done_at = k;
            k++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    int strobes;
    int done_at;

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        bus0.start = 1'b0; bus0.stop = 1'b0; bus0.song_sel = 1'b0; bus0.loop = 1'b0;

        //                start stop sel loop  fn    busy strobe done
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd39, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd39, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd39, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd27, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd27, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd27, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};

        // Reset state and release without start
        #12;
        check("reset_outs", 32'(obs(0)), 32'd0);
        check("reset_outs_g0", 32'(obs(1)), 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("post_reset_idle%0d", i), 32'(obs(0)), 32'd0);
        end

        // Song 0, no loop: full trace, strobe count, done timing
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        push_song(0, 1);
        exp_q.push_back({8'd0, 1'b0, 1'b0, 1'b1});
        exp_q.push_back({8'd0, 1'b0, 1'b0, 1'b0});
        run_trace("song0", 1'b0, strobes, done_at);
        check("song0_strobes", 32'(strobes), 32'd4);
        check("song0_done_at", 32'(done_at), 32'd46);

        // Song 1 looping: two passes then the third pass begins, never done
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        push_song(1, 1);
        push_song(1, 1);
        push_load();
        run_trace("song1_loop", 1'b0, strobes, done_at);
        check("song1_loop_strobes", 32'(strobes), 32'd10);
        check("song1_loop_no_done", 32'(done_at), 32'hFFFF_FFFF);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        check("song1_loop_stop", 32'(obs(0)), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);

        // Short per-cycle vectors: restart, stop+start priority, stop without done
        for (int i = 0; i < 17; i++) begin
            set_in(vecs[i].start, vecs[i].stop, vecs[i].song_sel, vecs[i].loop);
            cyc();
            check($sformatf("vec%0d", i), 32'(obs(0)),
                  32'({vecs[i].fn, vecs[i].busy, vecs[i].strobe, vecs[i].done}));
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);

        // Stop in the middle of entry 2 of song 0
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.start = 1'b0;
        idle_cycles(20);
        check("stop_e2_playing", 32'(bus.fullnote), 32'd34);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        check("stop_e2_idle", 32'(obs(0)), 32'd0);
        cyc();
        check("stop_e2_no_done", 32'(obs(0)), 32'd0);

        // Restart into song 1 while entry 1 of song 0 plays
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.start = 1'b0;
        idle_cycles(10);
        check("restart_e1_playing", 32'(bus.fullnote), 32'd31);
        set_in(1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        bus.start = 1'b0;
        check("restart_load", 32'(obs(0)), 32'({8'd0, 1'b1, 1'b0, 1'b0}));
        cyc();
        check("restart_song1", 32'(obs(0)), 32'({8'd39, 1'b1, 1'b1, 1'b0}));

        // Asynchronous reset mid-note, then no activity without start
        cyc();
        check("pre_reset_note", 32'(bus.fullnote), 32'd39);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outs", 32'(obs(0)), 32'd0);
        check("async_reset_state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("after_reset_idle%0d", i), 32'(obs(0)), 32'd0);
        end

        // No-gap instance, song 1
        bus0.song_sel = 1'b1; bus0.loop = 1'b0; bus0.start = 1'b1;
        push_song(1, 0);
        exp_q.push_back({8'd0, 1'b0, 1'b0, 1'b1});
        run_trace("nogap_song1", 1'b1, strobes, done_at);
        check("nogap_strobes", 32'(strobes), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
